// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_pkg
// Brief    : Shared state encoding and ALU function codes for alu_share_arb.
// Revision : 1.0  initial release
// ============================================================================
package alu_share_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] SUB = 6'b000001;
    localparam logic [5:0] AND = 6'b011000;
    localparam logic [5:0] OR  = 6'b011110;
    localparam logic [5:0] SLL = 6'b100000;
    localparam logic [5:0] EQ  = 6'b110011;
    localparam logic [5:0] LT  = 6'b110101;

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first valid index at or after
//            rr_ptr with wrap-around, as one-hot grant plus binary index.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    function automatic int wrap_idx(input int base, input int k);
        int j;
        j = base + k;
        if (j >= NREQ) j = j - NREQ;
        return j;
    endfunction

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(int'(rr_ptr), k)]) begin
                grant                             = '0;
                grant[wrap_idx(int'(rr_ptr), k)]  = 1'b1;
                grant_idx                         = IDW'(wrap_idx(int'(rr_ptr), k));
                grant_any                         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Brief    : Round-robin sharing of one ALU among NREQ requesters with a held
//            response port. Optional ALU_SHARE_ARB_OVF_EXC_EN adds rsp_exc.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*32-1:0] req_A,
    input  logic [NREQ*32-1:0] req_B,
    input  logic [NREQ*6-1:0]  req_ALUFun,
    input  logic [NREQ-1:0]  req_Sign,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [5:0]       alu_ALUFun,
    output logic             alu_Sign,
    input  logic [31:0]      alu_Z,
    input  logic             alu_V,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [31:0]      rsp_Z,
    output logic             rsp_V
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
    ,
    output logic             rsp_exc
`endif
);

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id_q;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_take;
    logic [IDW-1:0]  w_next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .grant_any (w_any)
    );

    // A grant only exists for a valid requester, so w_any is the handshake.
    assign w_take     = (r_state == IDLE) && !reset && w_any;
    assign req_ready  = w_take ? w_grant : '0;
    assign w_next_ptr = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + IDW'(1);

`ifdef ALU_SHARE_ARB_OVF_EXC_EN
    logic w_exc;
    assign w_exc = alu_V & alu_Sign & (alu_ALUFun[5:4] == 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_id_q     <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_ALUFun <= '0;
            alu_Sign   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_Z      <= '0;
            rsp_V      <= 1'b0;
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
            rsp_exc    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        alu_A      <= req_A[int'(w_idx)*32 +: 32];
                        alu_B      <= req_B[int'(w_idx)*32 +: 32];
                        alu_ALUFun <= req_ALUFun[int'(w_idx)*6 +: 6];
                        alu_Sign   <= req_Sign[w_idx];
                        r_id_q     <= w_idx;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
                    rsp_Z   <= w_exc ? 32'h0 : alu_Z;
                    rsp_exc <= w_exc;
`else
                    rsp_Z   <= alu_Z;
`endif
                    rsp_V     <= alu_V;
                    rsp_id    <= r_id_q;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Brief    : Directed self-checking bench for alu_share_arb with an ALU model
//            and an expected-response queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;
    import alu_share_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_A;
    logic [NREQ*32-1:0] req_B;
    logic [NREQ*6-1:0]  req_ALUFun;
    logic [NREQ-1:0]    req_Sign;
    logic [31:0]        alu_A, alu_B, alu_Z;
    logic [5:0]         alu_ALUFun;
    logic               alu_Sign, alu_V;
    logic               rsp_valid, rsp_ready, rsp_V;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_Z;
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
    logic               rsp_exc;
`endif

    alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_ALUFun (req_ALUFun),
        .req_Sign   (req_Sign),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_ALUFun (alu_ALUFun),
        .alu_Sign   (alu_Sign),
        .alu_Z      (alu_Z),
        .alu_V      (alu_V),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_Z      (rsp_Z),
        .rsp_V      (rsp_V)
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
        ,
        .rsp_exc    (rsp_exc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    z;
        logic           v;
        logic           exc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_ptr = 0;
    logic [31:0] ta[NREQ];
    logic [31:0] tb_b[NREQ];
    logic [5:0]  tf[NREQ];
    logic        ts[NREQ];

    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic s);
        logic [32:0] w;
        logic [31:0] z;
        logic        v;
        w = '0;
        z = '0;
        v = 1'b0;
        case (f)
            ADD: begin
                w = {1'b0, a} + {1'b0, b};
                z = w[31:0];
                v = s ? ((a[31] == b[31]) && (z[31] != a[31])) : w[32];
            end
            SUB: begin
                w = {1'b0, a} - {1'b0, b};
                z = w[31:0];
                v = s ? ((a[31] != b[31]) && (z[31] != a[31])) : w[32];
            end
            AND:     z = a & b;
            OR:      z = a | b;
            SLL:     z = a << b[4:0];
            EQ:      z = {31'b0, a == b};
            LT:      z = {31'b0, s ? ($signed(a) < $signed(b)) : (a < b)};
            default: z = a;
        endcase
        return {v, z};
    endfunction

    // Behavioural shared ALU driven by the DUT's registered operands.
    assign {alu_V, alu_Z} = alu_f(alu_A, alu_B, alu_ALUFun, alu_Sign);

    function automatic exp_t mk_exp(input int id);
        logic [32:0] r;
        exp_t        e;
        r     = alu_f(ta[id], tb_b[id], tf[id], ts[id]);
        e.id  = IDW'(id);
        e.v   = r[32];
        e.exc = r[32] & ts[id] & (tf[id][5:4] == 2'b00);
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
        e.z   = e.exc ? 32'h0 : r[31:0];
`else
        e.z   = r[31:0];
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] f, input logic s, input logic v);
        ta[idx]   = a;
        tb_b[idx] = b;
        tf[idx]   = f;
        ts[idx]   = s;
        req_A[idx*32 +: 32]    = a;
        req_B[idx*32 +: 32]    = b;
        req_ALUFun[idx*6 +: 6] = f;
        req_Sign[idx]          = s;
        req_valid[idx]         = v;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                return;
            end
            @(negedge clk);
        end
        chk("grant_timeout", 32'(req_ready != '0), 32'd1);
    endtask

    // Expected grant is the first valid requester from the bench's own pointer.
    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic op_cycle(input int hold, input bit drop);
        int   g;
        int   eg;
        exp_t e;
        eg = model_grant();
        wait_grant(g);
        if (g < 0) return;
        chk("grant_idx", 32'(g), 32'(eg));
        chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        exp_ptr = (g + 1) % NREQ;
        sb.push_back(mk_exp(g));
        @(negedge clk);
        if (drop) req_valid = '0;
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_alufun", 32'(alu_ALUFun), 32'(tf[g]));
        chk("exec_alu_a", alu_A, ta[g]);
        chk("exec_alu_b", alu_B, tb_b[g]);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_Z", rsp_Z, e.z);
        chk("rsp_V", 32'(rsp_V), 32'(e.v));
`ifdef ALU_SHARE_ARB_OVF_EXC_EN
        chk("rsp_exc", 32'(rsp_exc), 32'(e.exc));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_Z", rsp_Z, e.z);
            chk("hold_id", 32'(rsp_id), 32'(e.id));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("resp_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int g;
        reset      = 1'b1;
        req_valid  = '0;
        req_A      = '0;
        req_B      = '0;
        req_ALUFun = '0;
        req_Sign   = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_Z", rsp_Z, 32'd0);
        chk("rst_rsp_V", 32'(rsp_V), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_A", alu_A, 32'd0);
        chk("rst_alu_B", alu_B, 32'd0);
        chk("rst_alu_fun", 32'(alu_ALUFun), 32'd0);
        chk("rst_alu_sign", 32'(alu_Sign), 32'd0);
        @(negedge clk);

        // Single requests, each dropping valid after its grant.
        set_req(0, 32'd5, 32'd3, ADD, 1'b1, 1'b1);           op_cycle(0, 1'b1);
        set_req(1, 32'h7FFFFFFF, 32'd1, ADD, 1'b1, 1'b1);    op_cycle(0, 1'b1);
        set_req(0, 32'd10, 32'd3, SUB, 1'b0, 1'b1);          op_cycle(0, 1'b1);
        set_req(0, 32'd7, 32'd7, SUB, 1'b0, 1'b1);           op_cycle(0, 1'b1);
        set_req(0, 32'd7, 32'd7, EQ, 1'b0, 1'b1);            op_cycle(0, 1'b1);
        set_req(1, 32'd1, 32'd4, SLL, 1'b0, 1'b1);           op_cycle(0, 1'b1);
        set_req(1, 32'hFFFFFFFF, 32'd1, LT, 1'b1, 1'b1);     op_cycle(0, 1'b1);
        set_req(0, 32'hF0F0_1234, 32'h0FF0_00FF, AND, 1'b0, 1'b1); op_cycle(0, 1'b1);

        // Continuous contention: grants must alternate.
        for (int k = 0; k < 6; k++) begin
            set_req(0, 32'd100 + 32'(k), 32'd1, ADD, 1'b0, 1'b1);
            set_req(1, 32'h1000 << k, 32'h0F, OR, 1'b0, 1'b1);
            op_cycle(0, 1'b0);
        end

        // Backpressure with the other requester still waiting.
        set_req(0, 32'd20, 32'd22, ADD, 1'b0, 1'b1);
        set_req(1, 32'd9, 32'd4, SUB, 1'b1, 1'b1);
        op_cycle(5, 1'b0);
        op_cycle(0, 1'b1);

        // Reset during EXEC aborts the operation and clears the pointer.
        set_req(0, 32'd1, 32'd2, ADD, 1'b0, 1'b1);
        wait_grant(g);
        chk("abort_grant", 32'(g), 32'd0);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_alu_A", alu_A, 32'd0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        exp_ptr = 0;
        set_req(0, 32'd40, 32'd2, ADD, 1'b0, 1'b1);
        set_req(1, 32'd50, 32'd3, ADD, 1'b0, 1'b1);
        op_cycle(0, 1'b1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
